// File: rtl/cdc_feeder_pkg.sv
// Shared types and constants for the cdc_bus_feeder block and its FIFO.
package cdc_feeder_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      BUSY  = 2'd2
   } state_t;

   // Occupancy needs one bit more than the pointers so that "full" is representable.
   function automatic int lvl_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   localparam state_t      RST_STATE = IDLE;
   localparam logic        RST_READY = 1'b0;
   localparam logic [31:0] RST_STAT  = 32'd0;

endpackage

// File: rtl/cdc_bus_feeder_if.sv
// Word stream used on both sides of cdc_bus_feeder: data, valid and the return ready.
interface cdc_bus_feeder_if #(
   parameter int BUS_WIDTH = 32
);

   logic [BUS_WIDTH-1:0] bus;
   logic                 valid;
   logic                 ready;

   modport master (
      output bus,
      output valid,
      input  ready
   );

   modport slave (
      input  bus,
      input  valid,
      output ready
   );

endinterface

// File: rtl/sync_fifo_lite.sv
// Single-clock FIFO with flush; head word is visible on pop_data without a read latency.
module sync_fifo_lite
   import cdc_feeder_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                    aclk,
   input  logic                    arstn,
   input  logic                    push,
   input  logic [WIDTH-1:0]        push_data,
   input  logic                    pop,
   output logic [WIDTH-1:0]        pop_data,
   input  logic                    flush,
   output logic                    full,
   output logic                    empty,
   output logic [lvl_w(DEPTH)-1:0] level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = lvl_w(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [LVL_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == LVL_W'(DEPTH));
   assign empty    = (count == '0);
   assign level    = count;
   assign pop_data = mem[rd_ptr];

   // Flush wins over both operations on the same edge.
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + LVL_W'(1);
            2'b01:   count <= count - LVL_W'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage has no reset; only the pointers and count decide which words are live.
   always_ff @(posedge aclk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/cdc_bus_feeder.sv
// Queues upstream words and issues each as a one-cycle request pulse to a CDC bridge.
// Optional activity counters are compiled in with `define CDC_FEEDER_STATS_EN.
module cdc_bus_feeder
   import cdc_feeder_pkg::*;
#(
   parameter int BUS_WIDTH = 32,
   parameter int DEPTH     = 8
) (
   input  logic                    aclk,
   input  logic                    arstn,
   cdc_bus_feeder_if.slave         s,
   input  logic                    s_flush,
   cdc_bus_feeder_if.master        m,
   output logic [lvl_w(DEPTH)-1:0] level
`ifdef CDC_FEEDER_STATS_EN
   ,
   output logic [31:0]             stat_sent,
   output logic [lvl_w(DEPTH)-1:0] stat_hwm
`endif
);

   state_t               state_q;
   state_t               state_d;
   logic [BUS_WIDTH-1:0] head;
   logic [BUS_WIDTH-1:0] m_bus_q;
   logic                 rdy_q;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 push;
   logic                 pop;

   // rdy_q keeps s_ready low while in reset; afterwards only the registered level matters.
   assign s.ready = rdy_q && !fifo_full;
   assign push    = s.valid && s.ready;

   sync_fifo_lite #(
      .WIDTH (BUS_WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .aclk      (aclk),
      .arstn     (arstn),
      .push      (push),
      .push_data (s.bus),
      .pop       (pop),
      .pop_data  (head),
      .flush     (s_flush),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (level)
   );

   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         rdy_q <= RST_READY;
      end else begin
         rdy_q <= 1'b1;
      end
   end

   // NOTE: defaults first so no path through this block leaves an output unassigned.
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            // A flush on this edge empties the queue, so nothing may be taken from it.
            if (!fifo_empty && m.ready && !s_flush) begin
               pop     = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            state_d = BUSY;
         end
         BUSY: begin
            if (m.ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         state_q <= RST_STATE;
         m_bus_q <= '0;
      end else begin
         state_q <= state_d;
         if (pop) begin
            m_bus_q <= head;
         end
      end
   end

   // The request lasts exactly the ISSUE cycle, so it cannot repeat on back-to-back cycles.
   assign m.valid = (state_q == ISSUE);
   assign m.bus   = m_bus_q;

`ifdef CDC_FEEDER_STATS_EN
   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         stat_sent <= RST_STAT;
         stat_hwm  <= '0;
      end else begin
         if (m.valid) begin
            stat_sent <= stat_sent + 32'd1;
         end
         if (level > stat_hwm) begin
            stat_hwm <= level;
         end
      end
   end
`endif

endmodule
